// File: rtl/alu_result_stage_pkg.sv
// rtl/alu_result_stage_pkg.sv - shared op codes, flag indices and entry layout for the ALU result stage
package alu_result_stage_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_TAG_W  = 5;

    typedef struct packed {
        logic [ENTRY_DATA_W-1:0] data;
        logic [ENTRY_TAG_W-1:0]  tag;
        logic [3:0]              flags;
    } entry_t;

    // Carry and overflow carry no meaning for the bitwise ops.
    function automatic logic is_logic_op(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/alu_result_skid.sv
// rtl/alu_result_skid.sv - 2-entry valid/ready skid buffer with registered in_ready and flop-driven outputs
module alu_result_skid #(
    parameter int WIDTH = 41
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic [1:0]       count_next;
    logic [WIDTH-1:0] spare;
    logic             push;
    logic             pop;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // out_data is the head slot itself; spare holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            spare     <= '0;
        end else begin
            count     <= count_next;
            in_ready  <= (count_next != 2'd2);
            out_valid <= (count_next != 2'd0);
            if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                out_data <= in_data;
            end else if (pop && (count == 2'd2)) begin
                out_data <= spare;
            end
            if (push && (count == 2'd1) && !pop) begin
                spare <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - resolves ALU result/flags, buffers them toward writeback, counts signed overflows
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 5,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [TAG_W-1:0]     in_tag,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 alu_cout,
    input  logic                 alu_zero,
    input  logic                 alu_set,
    input  logic                 alu_overflow,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags,
    input  logic                 ovf_clr,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam int ENTRY_W = DATA_W + TAG_W + 4;
    localparam logic [OVF_CNT_W-1:0] OVF_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

    logic                is_slt;
    logic                logic_op;
    logic                accept;
    logic                ovf_inc;
    logic [DATA_W-1:0]   res;
    logic [3:0]          flags;
    logic [ENTRY_W-1:0]  head;

    // alu_zero describes the adder output, not the selected result, so Z is rebuilt here.
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;

    assign is_slt   = (in_op == OP_SLT);
    assign logic_op = is_logic_op(in_op);
    assign accept   = in_valid && in_ready;
    assign ovf_inc  = accept && flags[FLAG_V];

    always_comb begin
        res = is_slt ? {{(DATA_W-1){1'b0}}, alu_set ^ alu_overflow} : alu_result;
        flags         = 4'b0000;
        flags[FLAG_N] = res[DATA_W-1];
        flags[FLAG_Z] = (res == '0);
        flags[FLAG_C] = !logic_op && alu_cout;
        flags[FLAG_V] = !logic_op && alu_overflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= ovf_inc ? OVF_ONE : '0;
        end else if (ovf_inc && (ovf_count != '1)) begin
            ovf_count <= ovf_count + OVF_ONE;
        end
    end

    // Entry layout {data, tag, flags} matches entry_t.
    alu_result_skid #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({res, in_tag, flags}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign {out_data, out_tag, out_flags} = head;

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - table-driven scoreboard bench for alu_result_stage
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_tag;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        alu_zero;
    logic        alu_set;
    logic        alu_overflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic [3:0]  out_flags;
    logic        ovf_clr;
    logic [7:0]  ovf_count;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  tag;
        logic [31:0] res;
        logic        c;
        logic        s;
        logic        v;
        logic [31:0] ed;
        logic [3:0]  ef;
    } vec_t;

    vec_t   vt[9];
    vec_t   va, vb, vc, vo;
    entry_t q[$];
    int     errors = 0;
    int     checks = 0;
    int     exp_ovf = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_tag       (in_tag),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_zero     (alu_zero),
        .alu_set      (alu_set),
        .alu_overflow (alu_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_flags    (out_flags),
        .ovf_clr      (ovf_clr),
        .ovf_count    (ovf_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; outputs are read on the falling edge.
    task automatic send(input vec_t v);
        int     n;
        entry_t e;
        n = 0;
        in_valid     = 1'b1;
        in_op        = v.op;
        in_tag       = v.tag;
        alu_result   = v.res;
        alu_cout     = v.c;
        alu_set      = v.s;
        alu_overflow = v.v;
        alu_zero     = ~v.c;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        check("send_ready", in_ready, 1);
        if (!in_ready) begin
            in_valid = 1'b0;
            return;
        end
        e.data  = v.ed;
        e.tag   = v.tag;
        e.flags = v.ef;
        q.push_back(e);
        if (ovf_clr) exp_ovf = v.ef[0] ? 1 : 0;
        else if (v.ef[0] && exp_ovf != 255) exp_ovf++;
        @(posedge clk); #2;
        in_valid = 1'b0;
        check("ovf_count", ovf_count, exp_ovf);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain_empty", q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", {out_data, out_tag, out_flags}, 0);
            end else begin
                entry_t e;
                e = q.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", out_tag, e.tag);
                check("out_flags", out_flags, e.flags);
            end
        end
    end

    initial begin
        vt[0] = '{OP_ADD,  5'd3,  32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1001};
        vt[1] = '{OP_SLT,  5'd4,  32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'b0101};
        vt[2] = '{OP_SLT,  5'd5,  32'h8000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 4'b0000};
        vt[3] = '{OP_AND,  5'd6,  32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'b0100};
        vt[4] = '{OP_OR,   5'd7,  32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 4'b1000};
        vt[5] = '{OP_SUB,  5'd8,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0110};
        vt[6] = '{OP_ADD,  5'd9,  32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0110};
        vt[7] = '{3'b100,  5'd10, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 4'b0010};
        vt[8] = '{OP_SUB,  5'd11, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 4'b0011};
        va = '{OP_OR,  5'd7,  32'h0000_0011, 1'b0, 1'b0, 1'b0, 32'h0000_0011, 4'b0000};
        vb = '{OP_ADD, 5'd8,  32'h0000_0022, 1'b0, 1'b0, 1'b0, 32'h0000_0022, 4'b0000};
        vc = '{OP_SUB, 5'd9,  32'h0000_0033, 1'b1, 1'b0, 1'b0, 32'h0000_0033, 4'b0010};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_tag = 5'd0; alu_result = 32'd0;
        alu_cout = 1'b0; alu_zero = 1'b0; alu_set = 1'b0; alu_overflow = 1'b0;
        out_ready = 1'b1; ovf_clr = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_all", {out_data, out_tag, out_flags}, 0);
        check("rst_ovf_count", ovf_count, 0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        check("ready_before_edge", in_ready, 0);
        @(posedge clk); #2;
        check("ready_after_edge", in_ready, 1);

        for (int i = 0; i < 9; i++) send(vt[i]);
        drain();

        out_ready = 1'b0;
        send(va);
        check("bp_ready_after_one", in_ready, 1);
        check("bp_valid_after_one", out_valid, 1);
        send(vb);
        check("bp_ready_full", in_ready, 0);
        in_valid = 1'b1; in_op = vc.op; in_tag = vc.tag; alu_result = vc.res;
        repeat (3) begin
            @(posedge clk); #2;
        end
        check("bp_ready_hold", in_ready, 0);
        check("bp_head_data_hold", out_data, va.ed);
        check("bp_head_tag_hold", out_tag, va.tag);
        out_ready = 1'b1;
        send(vc);
        drain();

        for (int i = 0; i < 300; i++) begin
            vo = vt[0];
            vo.tag = i[4:0];
            send(vo);
        end
        check("ovf_saturated", ovf_count, 255);
        ovf_clr = 1'b1;
        send(vt[0]);
        ovf_clr = 1'b0;
        check("ovf_clr_with_inc", ovf_count, 1);
        ovf_clr = 1'b1;
        @(posedge clk); #2;
        ovf_clr = 1'b0;
        exp_ovf = 0;
        check("ovf_clr_alone", ovf_count, 0);
        drain();

        out_ready = 1'b0;
        send(vt[0]);
        send(vt[8]);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_in_ready", in_ready, 0);
        check("async_rst_out_all", {out_data, out_tag, out_flags}, 0);
        check("async_rst_ovf", ovf_count, 0);
        q.delete();
        exp_ovf = 0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        check("rerst_ready_before_edge", in_ready, 0);
        @(posedge clk); #2;
        check("rerst_ready_after_edge", in_ready, 1);
        check("rerst_valid_empty", out_valid, 0);
        out_ready = 1'b1;
        send(vt[7]);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
